uart_boot_loader: RTL and testbench
===================================

Name: uart_boot_loader

Overview:
Sequencer that sits between the UART byte receiver and the instruction memory write port. It holds the CPU in reset while it parses a length header and packs incoming bytes into little-endian 32-bit words. It writes those words to consecutive memory addresses, then releases the CPU. It also detects timeouts, overruns and oversize images.

Parameters:
ADDR_WIDTH, 12, word-address width of memory write port
BASE_ADDR, 0, word address of first payload word
MAX_WORDS, 4096, largest accepted image length in words
TIMEOUT_CYCLES, 1200000, idle clock cycles allowed between bytes once a load has started

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
rxData  input  8  received byte from UART receiver
rxValid  input  1  one-cycle strobe, rxData valid (already synchronous to clock)
restart  input  1  one-cycle pulse, leave DONE/ERROR and await new image
memAddr  output  ADDR_WIDTH  word address of write
memWdata  output  32  write data
memWe  output  1  write request, held until acknowledged
memAck  input  1  write accepted this cycle
cpuHold  output  1  1 = keep CPU in reset
loadDone  output  1  image fully written
loadError  output  1  load aborted
wordCount  output  ADDR_WIDTH+1  words written so far

Behaviour:
- All outputs are registered. Reset values: state=HDR, cpuHold=1, memWe=0, memAddr=BASE_ADDR, memWdata=0, loadDone=0, loadError=0, wordCount=0. The byte counter, length register and timeout counter are also cleared.
- Bytes are packed little-endian: the first byte of each group of 4 goes to bits 7:0.
- HDR state:
  - Collects 4 bytes into a 32-bit length, in words.
  - When the 4th byte is captured:
    - length==0 -> DONE.
    - length>MAX_WORDS -> ERROR.
    - otherwise -> DATA.
- DATA state:
  - Collects 4 bytes into the word register.
  - On the cycle after the 4th byte: state=WRITE, memWe=1, memAddr=BASE_ADDR+wordCount, memWdata=packed word.
- WRITE state:
  - memWe, memAddr and memWdata stay stable until memAck is sampled high.
  - On that edge: memWe=0 and wordCount increments.
  - If the new wordCount==length -> DONE, otherwise -> DATA.
  - A memAck that arrives while memWe=0 is ignored.
- Byte during WRITE:
  - A single-entry holding register stores the byte, and it is consumed on the first cycle back in DATA.
  - A second byte while the holding register is full -> ERROR (overrun).
- Timeout:
  - The counter is cleared on every rxValid and counts in HDR (after at least one header byte), DATA and WRITE.
  - Reaching TIMEOUT_CYCLES -> ERROR.
  - The counter is frozen in HDR before the first byte, and in DONE and ERROR.
- DONE: cpuHold=0 and loadDone=1 from the first cycle in DONE. rxValid is ignored.
- ERROR: cpuHold=1 and loadError=1, both sticky. rxValid is ignored. Any pending memWe is dropped the same edge.
- restart in DONE or ERROR:
  - Next edge -> HDR.
  - cpuHold=1; loadDone, loadError and wordCount are cleared; the holding register is emptied.
  - restart in any other state is ignored.
- Simultaneous events:
  - rxValid and memAck on the same edge: the ack is processed and the byte goes to the holding register.
  - Timeout and rxValid on the same edge: rxValid wins and the counter clears.
- Asserting reset mid-write drops memWe immediately (asynchronous). There is no partial-word commit.

Decomposition:
- Package uart_boot_pkg holds:
  - state enum (HDR, DATA, WRITE, DONE, ERROR);
  - byte-index type (2 bits);
  - LEN_BYTES=4 constant.
- One sub-module, uart_byte_packer: shift/pack register with the 2-bit byte index. It exposes a wordReady pulse and the word. The top module instantiates it and shares it between HDR and DATA.

Test Plan:
- Header 02 00 00 00, then payload 78 56 34 12 EF BE AD DE, with memAck one cycle after memWe -> writes 0x12345678 @BASE+0 and 0xDEADBEEF @BASE+1, wordCount=2, loadDone=1, cpuHold=0.
- Header 00 00 00 00 -> DONE with no memWe pulse, cpuHold drops the cycle after the 4th byte.
- Header 01 10 00 00 (4097) with MAX_WORDS=4096 -> loadError=1, cpuHold=1, later bytes ignored; a restart pulse returns to HDR with flags cleared.
- memAck delayed 20 cycles during write 0 while two bytes arrive -> the first byte is held and the second causes ERROR. With only one byte arriving, the load completes correctly.
- After 3 payload bytes, stop sending for TIMEOUT_CYCLES (set to 100) -> loadError=1 at cycle 100, and no partial write occurs.
- Assert reset while memWe=1 -> memWe=0 and cpuHold=1 immediately. The full image resent after reset loads correctly.

Source files
------------

// File: rtl/uart_boot_pkg.sv
// uart_boot_pkg: shared types and constants for the UART boot loader.
package uart_boot_pkg;
    typedef enum logic [2:0] {HDR, DATA, WRITE, DONE, ERROR} state_t;
    typedef logic [1:0] byte_idx_t;
    localparam int LEN_BYTES = 4;
endpackage

// File: rtl/uart_byte_packer.sv
// uart_byte_packer: packs bytes little-endian into 32-bit words, pulsing word_ready_o on the 4th byte.
module uart_byte_packer
    import uart_boot_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        word_ready_o,
    output logic [31:0] word_o,
    output byte_idx_t   byte_idx_o
);
    logic [23:0] word_q;
    byte_idx_t   idx_q;

    // word_o is the full word including the byte being captured this cycle
    assign word_o       = {byte_data_i, word_q};
    assign word_ready_o = byte_valid_i && idx_q == byte_idx_t'(LEN_BYTES - 1);
    assign byte_idx_o   = idx_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (clear_i) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (byte_valid_i) begin
            word_q <= word_o[31:8];
            idx_q  <= idx_q + 1'b1;
        end
    end
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: parses a length header, packs UART bytes into words, writes them to
// instruction memory and releases the CPU, flagging timeouts, overruns and oversize images.
module uart_boot_loader
    import uart_boot_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int BASE_ADDR      = 0,
    parameter int MAX_WORDS      = 4096,
    parameter int TIMEOUT_CYCLES = 1200000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            rxData,
    input  logic                  rxValid,
    input  logic                  restart,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [31:0]           memWdata,
    output logic                  memWe,
    input  logic                  memAck,
    output logic                  cpuHold,
    output logic                  loadDone,
    output logic                  loadError,
    output logic [ADDR_WIDTH:0]   wordCount
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                state_q, state_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  load_done_q, load_done_d;
    logic                  load_error_q, load_error_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic [31:0]           len_q, len_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [7:0]            hold_q, hold_d;
    logic                  hold_valid_q, hold_valid_d;

    logic                  pk_valid, pk_clear, pk_ready;
    logic [7:0]            pk_data;
    logic [31:0]           pk_word;
    byte_idx_t             pk_idx;
    logic                  active, counting, timeout, overrun;
    logic [ADDR_WIDTH:0]   wc_inc;

    // A held byte always starts a fresh word, so it is fed to the packer before any new byte
    assign pk_valid = (state_q == HDR && rxValid) || (state_q == DATA && (hold_valid_q || rxValid));
    assign pk_data  = (state_q == DATA && hold_valid_q) ? hold_q : rxData;
    assign pk_clear = restart && (state_q == DONE || state_q == ERROR);
    assign active   = state_q == HDR || state_q == DATA || state_q == WRITE;
    assign counting = state_q == DATA || state_q == WRITE || (state_q == HDR && pk_idx != '0);
    assign timeout  = active && !rxValid && counting && tmo_q == TW'(TIMEOUT_CYCLES - 1);
    assign wc_inc   = word_count_q + 1'b1;

    uart_byte_packer u_packer (
        .clock        (clock),
        .reset        (reset),
        .clear_i      (pk_clear),
        .byte_valid_i (pk_valid),
        .byte_data_i  (pk_data),
        .word_ready_o (pk_ready),
        .word_o       (pk_word),
        .byte_idx_o   (pk_idx)
    );

    always_comb begin
        state_d      = state_q;
        cpu_hold_d   = cpu_hold_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;
        word_count_d = word_count_q;
        len_d        = len_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        overrun      = 1'b0;
        tmo_d        = !active ? tmo_q : rxValid ? '0 : counting ? tmo_q + 1'b1 : tmo_q;
        case (state_q)
            HDR: begin
                if (pk_ready) begin
                    len_d = pk_word;
                    if (pk_word == '0) begin
                        state_d     = DONE;
                        cpu_hold_d  = 1'b0;
                        load_done_d = 1'b1;
                    end else if (pk_word > 32'(MAX_WORDS)) begin
                        state_d      = ERROR;
                        load_error_d = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (hold_valid_q) begin
                    hold_valid_d = rxValid;
                    hold_d       = rxData;
                end
                if (pk_ready) begin
                    state_d     = WRITE;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ADDR_WIDTH'(BASE_ADDR) + word_count_q[ADDR_WIDTH-1:0];
                    mem_wdata_d = pk_word;
                end
            end
            WRITE: begin
                if (memAck && mem_we_q) begin
                    mem_we_d     = 1'b0;
                    word_count_d = wc_inc;
                    if (32'(wc_inc) == len_q) begin
                        state_d     = DONE;
                        cpu_hold_d  = 1'b0;
                        load_done_d = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
                if (rxValid) begin
                    overrun      = hold_valid_q;
                    hold_d       = rxData;
                    hold_valid_d = 1'b1;
                end
            end
            DONE, ERROR: begin
                if (restart) begin
                    state_d      = HDR;
                    cpu_hold_d   = 1'b1;
                    load_done_d  = 1'b0;
                    load_error_d = 1'b0;
                    word_count_d = '0;
                    hold_valid_d = 1'b0;
                    tmo_d        = '0;
                end
            end
            default: state_d = HDR;
        endcase
        if (timeout || overrun) begin
            state_d      = ERROR;
            cpu_hold_d   = 1'b1;
            load_done_d  = 1'b0;
            load_error_d = 1'b1;
            mem_we_d     = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= HDR;
            cpu_hold_q   <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= ADDR_WIDTH'(BASE_ADDR);
            mem_wdata_q  <= '0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            word_count_q <= '0;
            len_q        <= '0;
            tmo_q        <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpu_hold_q   <= cpu_hold_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
            word_count_q <= word_count_d;
            len_q        <= len_d;
            tmo_q        <= tmo_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign memAddr   = mem_addr_q;
    assign memWdata  = mem_wdata_q;
    assign memWe     = mem_we_q;
    assign cpuHold   = cpu_hold_q;
    assign loadDone  = load_done_q;
    assign loadError = load_error_q;
    assign wordCount = word_count_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed bench with a write scoreboard and an auto-acking memory model.
module tb_uart_boot_loader;
    logic        clock, reset, rxValid, restart, memAck, memWe;
    logic        cpuHold, loadDone, loadError;
    logic [7:0]  rxData;
    logic [11:0] memAddr;
    logic [31:0] memWdata;
    logic [12:0] wordCount;

    typedef struct {logic [11:0] addr; logic [31:0] data;} wr_t;
    wr_t exp_q[$];
    wr_t mon_e;
    int compared = 0, mismatched = 0;
    int ack_delay = 1, ack_wait = 0, we_cycles = 0, we_snap = 0;
    bit ack_en = 1;

    uart_boot_loader #(
        .ADDR_WIDTH(12), .BASE_ADDR(16), .MAX_WORDS(4096), .TIMEOUT_CYCLES(100)
    ) dut (
        .clock(clock), .reset(reset), .rxData(rxData), .rxValid(rxValid), .restart(restart),
        .memAddr(memAddr), .memWdata(memWdata), .memWe(memWe), .memAck(memAck),
        .cpuHold(cpuHold), .loadDone(loadDone), .loadError(loadError), .wordCount(wordCount)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: acks after ack_delay cycles of memWe and scores the accepted write
    initial begin
        memAck = 0;
        forever begin
            @(negedge clock);
            if (memWe) we_cycles++;
            if (memAck) begin
                memAck = 0;
                ack_wait = 0;
            end else if (memWe && ack_en) begin
                ack_wait++;
                if (ack_wait >= ack_delay) begin
                    memAck = 1;
                    ack_wait = 0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", {20'd0, memAddr, memWdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("wr_addr", memAddr, mon_e.addr);
                        check("wr_data", memWdata, mon_e.data);
                    end
                end
            end else begin
                ack_wait = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        rxData = b;
        rxValid = 1;
        @(negedge clock);
        rxValid = 0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic pulse_restart();
        @(negedge clock);
        restart = 1;
        @(negedge clock);
        restart = 0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && loadDone !== 1'b1; i++) @(negedge clock);
    endtask

    initial begin
        reset = 1; rxData = 0; rxValid = 0; restart = 0;
        repeat (3) @(negedge clock);
        check("rst_hold", cpuHold, 1);
        check("rst_we", memWe, 0);
        check("rst_addr", memAddr, 16);
        check("rst_wdata", memWdata, 0);
        check("rst_done", loadDone, 0);
        check("rst_err", loadError, 0);
        check("rst_wc", wordCount, 0);
        reset = 0;

        // Two-word image
        exp_q.push_back('{addr: 12'd16, data: 32'h12345678});
        exp_q.push_back('{addr: 12'd17, data: 32'hDEADBEEF});
        send_word(2);
        send_word(32'h12345678);
        send_word(32'hDEADBEEF);
        wait_done(200);
        check("t1_done", loadDone, 1);
        check("t1_hold", cpuHold, 0);
        check("t1_wc", wordCount, 2);
        check("t1_err", loadError, 0);
        send_byte(8'h55);
        check("t1_ignore_wc", wordCount, 2);
        check("t1_ignore_done", loadDone, 1);
        pulse_restart();
        check("rs1_hold", cpuHold, 1);
        check("rs1_done", loadDone, 0);
        check("rs1_wc", wordCount, 0);

        // Zero-length image
        we_snap = we_cycles;
        repeat (3) send_byte(8'h00);
        check("t2_hold_before", cpuHold, 1);
        send_byte(8'h00);
        check("t2_hold", cpuHold, 0);
        check("t2_done", loadDone, 1);
        check("t2_no_we", we_cycles, we_snap);
        pulse_restart();

        // Oversize image (4097 words)
        send_word(32'h0000_1001);
        check("t3_err", loadError, 1);
        check("t3_hold", cpuHold, 1);
        send_word(32'h0000_0001);
        check("t3_err_sticky", loadError, 1);
        check("t3_wc", wordCount, 0);
        check("t3_no_we", we_cycles, we_snap);
        pulse_restart();
        check("rs3_err", loadError, 0);
        check("rs3_hold", cpuHold, 1);

        // Overrun: two bytes while a slow write is pending
        ack_delay = 20;
        send_word(1);
        send_word(32'hCAFEF00D);
        check("t4_we", memWe, 1);
        send_byte(8'h01);
        check("t4_held_ok", loadError, 0);
        send_byte(8'h02);
        check("t4_overrun", loadError, 1);
        check("t4_we_drop", memWe, 0);
        check("t4_wc", wordCount, 0);
        repeat (30) @(negedge clock);
        pulse_restart();

        // Single held byte during a slow write is consumed afterwards
        exp_q.push_back('{addr: 12'd16, data: 32'h11223344});
        exp_q.push_back('{addr: 12'd17, data: 32'h90A1B2C3});
        send_word(2);
        send_word(32'h11223344);
        send_byte(8'hC3);
        check("t4b_no_err", loadError, 0);
        for (int i = 0; i < 50 && memWe !== 1'b0; i++) @(negedge clock);
        check("t4b_acked", memWe, 0);
        check("t4b_wc1", wordCount, 1);
        send_byte(8'hB2);
        send_byte(8'hA1);
        send_byte(8'h90);
        wait_done(100);
        check("t4b_done", loadDone, 1);
        check("t4b_wc2", wordCount, 2);
        pulse_restart();
        ack_delay = 1;

        // Timeout: frozen before first header byte, fires 100 cycles after the last byte
        repeat (150) @(negedge clock);
        check("t5_idle_hdr", loadError, 0);
        we_snap = we_cycles;
        send_word(2);
        repeat (3) send_byte(8'hA5);
        repeat (99) @(negedge clock);
        check("t5_not_yet", loadError, 0);
        @(negedge clock);
        check("t5_timeout", loadError, 1);
        check("t5_no_we", we_cycles, we_snap);
        check("t5_wc", wordCount, 0);
        pulse_restart();

        // Asynchronous reset while a write is pending
        ack_en = 0;
        send_word(1);
        send_word(32'h0BADF00D);
        check("t6_we", memWe, 1);
        check("t6_addr", memAddr, 16);
        check("t6_wdata", memWdata, 32'h0BADF00D);
        repeat (3) @(negedge clock);
        check("t6_we_held", memWe, 1);
        #2 reset = 1;
        #1;
        check("t6_rst_we", memWe, 0);
        check("t6_rst_hold", cpuHold, 1);
        @(negedge clock);
        reset = 0;
        ack_en = 1;
        exp_q.push_back('{addr: 12'd16, data: 32'h0BADF00D});
        send_word(1);
        send_word(32'h0BADF00D);
        wait_done(100);
        check("t6_done", loadDone, 1);
        check("t6_wc", wordCount, 1);
        check("t6_hold", cpuHold, 0);
        check("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
